// File: rtl/vendor_dual_panel_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : vendor_dual_panel_ctrl_if
//  Description : Panel request/ack, core strobe/response and per-panel
//                result pulses shared between the dual-panel controller and
//                its environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface vendor_dual_panel_ctrl_if;
    // Panel coin requests (level, held until the matching ack)
    logic       req_a_x;
    logic       req_a_y;
    logic       req_b_x;
    logic       req_b_y;
    // Coin accepted pulses
    logic       ack_a;
    logic       ack_b;
    // Vending core strobes and Mealy responses
    logic       core_inx;
    logic       core_iny;
    logic       core_clr;
    logic       core_outo;
    logic       core_outz;
    // Per-panel result pulses
    logic       vend_a;
    logic       vend_b;
    logic       change_a;
    logic       change_b;
    logic       refund_a;
    logic       refund_b;
    logic [1:0] refund_amt;

    // Environment side: panels plus the vending core
    modport master (
        output req_a_x, req_a_y, req_b_x, req_b_y, core_outo, core_outz,
        input  ack_a, ack_b, core_inx, core_iny, core_clr,
        input  vend_a, vend_b, change_a, change_b,
        input  refund_a, refund_b, refund_amt
    );

    // Controller side
    modport slave (
        input  req_a_x, req_a_y, req_b_x, req_b_y, core_outo, core_outz,
        output ack_a, ack_b, core_inx, core_iny, core_clr,
        output vend_a, vend_b, change_a, change_b,
        output refund_a, refund_b, refund_amt
    );
endinterface
`default_nettype wire

// File: rtl/vendor_dual_panel_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : vendor_dual_panel_ctrl
//  Description : Shares one 15-cent vending core between two customer panels.
//                A panel owns the core from its first coin until dispense or
//                timeout; on timeout the tracked credit is refunded and the
//                core is cleared. Every output is registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module vendor_dual_panel_ctrl #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    vendor_dual_panel_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_OWN   = 3'd1,
        ST_ISSUE = 3'd2,
        ST_GAP   = 3'd3,
        ST_CLR   = 3'd4
    } state_t;

    localparam logic [1:0]       c_owner_none = 2'b00;
    localparam logic [1:0]       c_owner_a    = 2'b01;
    localparam logic [1:0]       c_owner_b    = 2'b10;
    localparam logic [CNT_W-1:0] c_timer_last = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_timer_one  = CNT_W'(1);

    // Session state
    state_t           state_q,  state_d;
    logic [1:0]       owner_q,  owner_d;
    logic             coin_q,   coin_d;      // coin in flight: 1 = 10c, 0 = 5c
    logic [1:0]       credit_q, credit_d;    // tracked credit in nickels
    logic             rr_ptr_q, rr_ptr_d;    // 0 = A wins next contention
    logic [CNT_W-1:0] timer_q,  timer_d;

    // Registered outputs
    logic       ack_a_q,      ack_a_d;
    logic       ack_b_q,      ack_b_d;
    logic       core_inx_q,   core_inx_d;
    logic       core_iny_q,   core_iny_d;
    logic       core_clr_q,   core_clr_d;
    logic       vend_a_q,     vend_a_d;
    logic       vend_b_q,     vend_b_d;
    logic       change_a_q,   change_a_d;
    logic       change_b_q,   change_b_d;
    logic       refund_a_q,   refund_a_d;
    logic       refund_b_q,   refund_b_d;
    logic [1:0] refund_amt_q, refund_amt_d;

    // Arbitration and coin-select helpers
    logic       want_a;
    logic       want_b;
    logic       grant_b;
    logic       idle_sel_y;
    logic       own_is_b;
    logic       own_x;
    logic       own_y;
    logic [1:0] coin_nickels;
    logic [2:0] coin_sum;

    assign want_a       = bus.req_a_x | bus.req_a_y;
    assign want_b       = bus.req_b_x | bus.req_b_y;
    // B wins when it is alone, or when both request and the pointer says B
    assign grant_b      = want_b & (~want_a | rr_ptr_q);
    // 5c has priority: pick 10c only when the granted panel's x is low
    assign idle_sel_y   = grant_b ? ~bus.req_b_x : ~bus.req_a_x;
    assign own_is_b     = (owner_q == c_owner_b);
    assign own_x        = own_is_b ? bus.req_b_x : bus.req_a_x;
    assign own_y        = own_is_b ? bus.req_b_y : bus.req_a_y;
    assign coin_nickels = coin_q ? 2'd2 : 2'd1;
    assign coin_sum     = {1'b0, credit_q} + {1'b0, coin_nickels};

    // Next-state and registered-output decode for the session FSM
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        coin_d       = coin_q;
        credit_d     = credit_q;
        rr_ptr_d     = rr_ptr_q;
        timer_d      = timer_q;
        ack_a_d      = 1'b0;
        ack_b_d      = 1'b0;
        core_inx_d   = 1'b0;
        core_iny_d   = 1'b0;
        core_clr_d   = 1'b0;
        vend_a_d     = 1'b0;
        vend_b_d     = 1'b0;
        change_a_d   = 1'b0;
        change_b_d   = 1'b0;
        refund_a_d   = 1'b0;
        refund_b_d   = 1'b0;
        refund_amt_d = 2'd0;

        case (state_q)
            ST_IDLE: begin
                if (want_a | want_b) begin
                    owner_d    = grant_b ? c_owner_b : c_owner_a;
                    if (want_a & want_b) begin
                        rr_ptr_d = ~rr_ptr_q;
                    end
                    coin_d     = idle_sel_y;
                    ack_a_d    = ~grant_b;
                    ack_b_d    = grant_b;
                    core_inx_d = ~idle_sel_y;
                    core_iny_d = idle_sel_y;
                    timer_d    = '0;
                    state_d    = ST_ISSUE;
                end
            end

            ST_OWN: begin
                if (own_x | own_y) begin
                    // The non-owner panel is never looked at here
                    coin_d     = ~own_x;
                    ack_a_d    = ~own_is_b;
                    ack_b_d    = own_is_b;
                    core_inx_d = own_x;
                    core_iny_d = ~own_x;
                    state_d    = ST_ISSUE;
                end else if (timer_q == c_timer_last) begin
                    core_clr_d   = 1'b1;
                    refund_a_d   = ~own_is_b;
                    refund_b_d   = own_is_b;
                    refund_amt_d = credit_q;
                    state_d      = ST_CLR;
                end else begin
                    timer_d = timer_q + c_timer_one;
                end
            end

            ST_ISSUE: begin
                // Core response is Mealy on the strobe now on the wires
                vend_a_d   = bus.core_outo & ~own_is_b;
                vend_b_d   = bus.core_outo & own_is_b;
                change_a_d = bus.core_outz & ~own_is_b;
                change_b_d = bus.core_outz & own_is_b;
                if (bus.core_outo) begin
                    credit_d = 2'd0;
                    owner_d  = c_owner_none;
                end else begin
                    credit_d = coin_sum[1:0];
                end
                timer_d = '0;
                state_d = ST_GAP;
            end

            ST_GAP: begin
                // Requests are not sampled here, so a req still held while
                // its ack is seen is not counted twice. This guard cycle is
                // the first idle cycle of the timeout window.
                timer_d = timer_q + c_timer_one;
                state_d = (owner_q == c_owner_none) ? ST_IDLE : ST_OWN;
            end

            ST_CLR: begin
                credit_d = 2'd0;
                owner_d  = c_owner_none;
                timer_d  = '0;
                state_d  = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= c_owner_none;
            coin_q       <= 1'b0;
            credit_q     <= 2'd0;
            rr_ptr_q     <= 1'b0;
            timer_q      <= '0;
            ack_a_q      <= 1'b0;
            ack_b_q      <= 1'b0;
            core_inx_q   <= 1'b0;
            core_iny_q   <= 1'b0;
            core_clr_q   <= 1'b0;
            vend_a_q     <= 1'b0;
            vend_b_q     <= 1'b0;
            change_a_q   <= 1'b0;
            change_b_q   <= 1'b0;
            refund_a_q   <= 1'b0;
            refund_b_q   <= 1'b0;
            refund_amt_q <= 2'd0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            coin_q       <= coin_d;
            credit_q     <= credit_d;
            rr_ptr_q     <= rr_ptr_d;
            timer_q      <= timer_d;
            ack_a_q      <= ack_a_d;
            ack_b_q      <= ack_b_d;
            core_inx_q   <= core_inx_d;
            core_iny_q   <= core_iny_d;
            core_clr_q   <= core_clr_d;
            vend_a_q     <= vend_a_d;
            vend_b_q     <= vend_b_d;
            change_a_q   <= change_a_d;
            change_b_q   <= change_b_d;
            refund_a_q   <= refund_a_d;
            refund_b_q   <= refund_b_d;
            refund_amt_q <= refund_amt_d;
        end
    end

    assign bus.ack_a      = ack_a_q;
    assign bus.ack_b      = ack_b_q;
    assign bus.core_inx   = core_inx_q;
    assign bus.core_iny   = core_iny_q;
    assign bus.core_clr   = core_clr_q;
    assign bus.vend_a     = vend_a_q;
    assign bus.vend_b     = vend_b_q;
    assign bus.change_a   = change_a_q;
    assign bus.change_b   = change_b_q;
    assign bus.refund_a   = refund_a_q;
    assign bus.refund_b   = refund_b_q;
    assign bus.refund_amt = refund_amt_q;

    // A healthy core dispenses exactly when the deposit reaches 15c
    a_core_dispense_consistent : assert property (
        @(posedge clk) disable iff (rst)
        (state_q == ST_ISSUE) |-> (bus.core_outo == (coin_sum >= 3'd3))
    );

endmodule
`default_nettype wire
